// File: rtl/hsid_x_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hsid_x_ctrl_pkg
//  Purpose  : Shared types and constants for the hyperspectral identification
//             controller: the FSM state encoding and the OBI word stride.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package hsid_x_ctrl_pkg;

  // Byte distance between consecutive 32-bit band words in memory.
  localparam int ADDR_STRIDE = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAP_REQ  = 3'd1,
    ST_CAP_WAIT = 3'd2,
    ST_REF_REQ  = 3'd3,
    ST_REF_WAIT = 3'd4,
    ST_RESULT   = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hsid_x_ctrl_min.sv
`default_nettype none
// ============================================================================
//  Module   : hsid_x_ctrl_min
//  Purpose  : Keeps the smallest distance seen so far and the library index
//             that produced it. A strict less-than compare means ties keep
//             the earlier (lower) index.
//  Ports    : clk, rst          - clock, async active-high reset
//             init              - load best_dist=all-ones, best_idx=0
//             update, res, idx  - candidate distance and its entry index
//             best_idx, best_dist - registered running minimum
//  Revision : 1.0 - initial release
// ============================================================================
module hsid_x_ctrl_min #(
  parameter int DATA_WIDTH_ACC = 48,
  parameter int IDX_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init,
  input  logic                      update,
  input  logic [DATA_WIDTH_ACC-1:0] res,
  input  logic [IDX_WIDTH-1:0]      idx,
  output logic [IDX_WIDTH-1:0]      best_idx,
  output logic [DATA_WIDTH_ACC-1:0] best_dist
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_idx  <= '0;
      best_dist <= '1;
    end else if (init) begin
      best_idx  <= '0;
      best_dist <= '1;
    end else if (update && (res < best_dist)) begin
      best_idx  <= idx;
      best_dist <= res;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hsid_x_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hsid_x_ctrl
//  Purpose  : Control FSM for a hyperspectral identification engine. Fetches
//             the captured pixel once, then every library entry over an OBI
//             read master, streams band samples to an external distance
//             datapath and tracks the best-matching entry.
//  Ports    : clk, rst                  - clock, async active-high reset
//             start_i, clear_i          - start pulse, irq clear
//             cap_addr_i, lib_addr_i,
//             lib_size_i, band_cnt_i    - job configuration (sampled at start)
//             obi_*                     - OBI read master
//             dp_*                      - sample stream out / distance in
//             busy_o, done_o, err_o,
//             best_idx_o, best_dist_o,
//             irq_o                     - status
//             abort_i                   - only with HSID_X_CTRL_ABORT_EN
//  Config   : `define HSID_X_CTRL_ABORT_EN adds the abort_i input.
//  Revision : 1.0 - initial release
// ============================================================================
module hsid_x_ctrl
  import hsid_x_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH       = 32,
  parameter int DATA_WIDTH       = 16,
  parameter int DATA_WIDTH_ACC   = 48,
  parameter int HSI_BANDS        = 128,
  parameter int HSI_LIBRARY_SIZE = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_i,
  input  logic                                clear_i,
`ifdef HSID_X_CTRL_ABORT_EN
  input  logic                                abort_i,
`endif
  input  logic [WORD_WIDTH-1:0]               cap_addr_i,
  input  logic [WORD_WIDTH-1:0]               lib_addr_i,
  input  logic [$clog2(HSI_LIBRARY_SIZE):0]   lib_size_i,
  input  logic [$clog2(HSI_BANDS):0]          band_cnt_i,
  output logic                                obi_req_o,
  output logic [WORD_WIDTH-1:0]               obi_addr_o,
  input  logic                                obi_gnt_i,
  input  logic                                obi_rvalid_i,
  input  logic [WORD_WIDTH-1:0]               obi_rdata_i,
  output logic                                dp_valid_o,
  output logic                                dp_cap_o,
  output logic                                dp_last_o,
  output logic [DATA_WIDTH-1:0]               dp_data_o,
  input  logic                                dp_res_valid_i,
  input  logic [DATA_WIDTH_ACC-1:0]           dp_res_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                err_o,
  output logic [$clog2(HSI_LIBRARY_SIZE)-1:0] best_idx_o,
  output logic [DATA_WIDTH_ACC-1:0]           best_dist_o,
  output logic                                irq_o
);

  localparam int LIB_W  = $clog2(HSI_LIBRARY_SIZE) + 1;
  localparam int BAND_W = $clog2(HSI_BANDS) + 1;
  localparam int IDX_W  = $clog2(HSI_LIBRARY_SIZE);
  localparam logic [WORD_WIDTH-1:0] STRIDE = WORD_WIDTH'(ADDR_STRIDE);

  state_t              state;
  logic [BAND_W-1:0]   band;       // band index within the current vector
  logic [BAND_W-1:0]   band_num;   // latched band count
  logic [LIB_W-1:0]    entry;      // current library entry
  logic [LIB_W-1:0]    lib_num;    // latched library size
  logic [WORD_WIDTH-1:0] ref_ptr;  // next reference word to request
  logic                abort_pend; // abort seen while a read is outstanding

  logic abort;
`ifdef HSID_X_CTRL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  logic wait_st, beat, squash, last_band, band_ok, accept;
  logic unused_rdata_hi;

  assign wait_st   = (state == ST_CAP_WAIT) || (state == ST_REF_WAIT);
  assign beat      = wait_st && obi_rvalid_i;
  // An aborted read still completes on the bus but is not forwarded.
  assign squash    = abort || abort_pend;
  assign last_band = (band == band_num - 1'b1);
  assign band_ok   = (band_cnt_i != '0) && (band_cnt_i <= BAND_W'(HSI_BANDS));
  assign accept    = (state == ST_IDLE) && start_i;

  assign dp_valid_o = beat && !squash;
  assign dp_cap_o   = dp_valid_o && (state == ST_CAP_WAIT);
  assign dp_last_o  = dp_valid_o && last_band;
  assign dp_data_o  = dp_valid_o ? obi_rdata_i[DATA_WIDTH-1:0] : '0;

  assign unused_rdata_hi = ^obi_rdata_i[WORD_WIDTH-1:DATA_WIDTH];

  hsid_x_ctrl_min #(
    .DATA_WIDTH_ACC (DATA_WIDTH_ACC),
    .IDX_WIDTH      (IDX_W)
  ) u_min (
    .clk       (clk),
    .rst       (rst),
    .init      (accept && band_ok),
    .update    ((state == ST_RESULT) && dp_res_valid_i && !abort),
    .res       (dp_res_i),
    .idx       (entry[IDX_W-1:0]),
    .best_idx  (best_idx_o),
    .best_dist (best_dist_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      band       <= '0;
      band_num   <= '0;
      entry      <= '0;
      lib_num    <= '0;
      ref_ptr    <= '0;
      abort_pend <= 1'b0;
      obi_req_o  <= 1'b0;
      obi_addr_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (clear_i) irq_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          abort_pend <= 1'b0;
          if (start_i) begin
            err_o  <= !band_ok;
            busy_o <= 1'b1;
            if (!band_ok || (lib_size_i == '0)) begin
              state <= ST_DONE;
            end else begin
              band_num   <= band_cnt_i;
              lib_num    <= lib_size_i;
              band       <= '0;
              entry      <= '0;
              ref_ptr    <= lib_addr_i;
              obi_addr_o <= cap_addr_i;
              obi_req_o  <= 1'b1;
              state      <= ST_CAP_REQ;
            end
          end
        end

        ST_CAP_REQ, ST_REF_REQ: begin
          if (abort) begin
            obi_req_o <= 1'b0;
            busy_o    <= 1'b0;
            state     <= ST_IDLE;
          end else if (obi_gnt_i) begin
            obi_req_o <= 1'b0;
            if (state == ST_REF_REQ) begin
              ref_ptr <= ref_ptr + STRIDE;
              state   <= ST_REF_WAIT;
            end else begin
              state   <= ST_CAP_WAIT;
            end
          end
        end

        ST_CAP_WAIT, ST_REF_WAIT: begin
          if (obi_rvalid_i) begin
            if (squash) begin
              abort_pend <= 1'b0;
              busy_o     <= 1'b0;
              state      <= ST_IDLE;
            end else if (last_band) begin
              band <= '0;
              if (state == ST_CAP_WAIT) begin
                obi_addr_o <= ref_ptr;
                obi_req_o  <= 1'b1;
                state      <= ST_REF_REQ;
              end else begin
                state      <= ST_RESULT;
              end
            end else begin
              band      <= band + 1'b1;
              obi_req_o <= 1'b1;
              if (state == ST_CAP_WAIT) begin
                obi_addr_o <= obi_addr_o + STRIDE;
                state      <= ST_CAP_REQ;
              end else begin
                // ref_ptr already advanced at the grant.
                obi_addr_o <= ref_ptr;
                state      <= ST_REF_REQ;
              end
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end

        ST_RESULT: begin
          if (abort) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else if (dp_res_valid_i) begin
            if (entry == lib_num - 1'b1) begin
              state <= ST_DONE;
            end else begin
              entry      <= entry + 1'b1;
              band       <= '0;
              obi_addr_o <= ref_ptr;
              obi_req_o  <= 1'b1;
              state      <= ST_REF_REQ;
            end
          end
        end

        ST_DONE: begin
          done_o <= 1'b1;
          irq_o  <= 1'b1;  // overrides a same-cycle clear
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          obi_req_o <= 1'b0;
          busy_o    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hsid_x_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hsid_x_ctrl
//  Purpose  : Directed self-checking bench for hsid_x_ctrl with an OBI slave
//             (programmable grant / rvalid latency) and a distance-result
//             responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hsid_x_ctrl;

  localparam int WW = 32;
  localparam int DW = 16;
  localparam int AW = 48;
  localparam logic [AW-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [WW-1:0] cap_addr_i = '0;
  logic [WW-1:0] lib_addr_i = '0;
  logic [8:0]    lib_size_i = '0;
  logic [7:0]    band_cnt_i = '0;
  logic          obi_req_o;
  logic [WW-1:0] obi_addr_o;
  logic          obi_gnt_i;
  logic          obi_rvalid_i;
  logic [WW-1:0] obi_rdata_i;
  logic          dp_valid_o, dp_cap_o, dp_last_o;
  logic [DW-1:0] dp_data_o;
  logic          dp_res_valid_i;
  logic [AW-1:0] dp_res_i;
  logic          busy_o, done_o, err_o, irq_o;
  logic [7:0]    best_idx_o;
  logic [AW-1:0] best_dist_o;

  hsid_x_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i),
    .cap_addr_i(cap_addr_i), .lib_addr_i(lib_addr_i),
    .lib_size_i(lib_size_i), .band_cnt_i(band_cnt_i),
    .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_gnt_i(obi_gnt_i),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
    .dp_valid_o(dp_valid_o), .dp_cap_o(dp_cap_o), .dp_last_o(dp_last_o),
    .dp_data_o(dp_data_o), .dp_res_valid_i(dp_res_valid_i), .dp_res_i(dp_res_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .best_idx_o(best_idx_o), .best_dist_o(best_dist_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int failures = 0;

  // responder configuration and monitor counters
  int gnt_dly = 0, rv_dly = 0;
  int res_q [8];
  int res_k = 0;
  int n_valid = 0, n_last = 0, n_cap = 0, n_done = 0, n_req = 0;
  int n_data_err = 0, n_unstable = 0, n_gnt = 0;
  logic [WW-1:0] gaddr [64];

  // Monitor samples at negedge; slave drives #1 after posedge.
  initial begin : responder
    logic s_valid, s_last, s_cap;
    logic [WW-1:0] cur_addr, rd_addr, hold_addr;
    int g_wait, rv_wait;
    bit rv_pending;
    obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = '0;
    dp_res_valid_i = 0; dp_res_i = '0;
    s_valid = 0; s_last = 0; s_cap = 0;
    cur_addr = '0; rd_addr = '0; hold_addr = '0;
    g_wait = 0; rv_wait = 0; rv_pending = 0;
    forever begin
      @(negedge clk);
      s_valid = dp_valid_o; s_last = dp_last_o; s_cap = dp_cap_o;
      if (s_valid) begin
        n_valid++;
        if (s_last) n_last++;
        if (s_cap) n_cap++;
        if (dp_data_o !== (rd_addr[15:0] ^ 16'hA5A5)) n_data_err++;
      end
      if (done_o) n_done++;
      if (obi_req_o) n_req++;
      @(posedge clk);
      #1;
      if (rst) begin
        obi_gnt_i = 0; obi_rvalid_i = 0; dp_res_valid_i = 0;
        rv_pending = 0; g_wait = 0;
      end else begin
        dp_res_valid_i = 0;
        if (s_valid && s_last && !s_cap && res_k < 8) begin
          dp_res_valid_i = 1;
          dp_res_i = AW'(res_q[res_k]);
          res_k++;
        end
        obi_rvalid_i = 0;
        if (obi_gnt_i) begin
          obi_gnt_i = 0; rv_pending = 1; rv_wait = rv_dly;
        end
        if (rv_pending) begin
          if (rv_wait == 0) begin
            obi_rvalid_i = 1; rd_addr = cur_addr;
            obi_rdata_i = {16'hDEAD, cur_addr[15:0] ^ 16'hA5A5};
            rv_pending = 0;
          end else rv_wait--;
        end else if (obi_req_o) begin
          if (g_wait == 0) hold_addr = obi_addr_o;
          else if (obi_addr_o !== hold_addr) n_unstable++;
          if (g_wait >= gnt_dly) begin
            obi_gnt_i = 1; cur_addr = obi_addr_o;
            if (n_gnt < 64) gaddr[n_gnt] = obi_addr_o;
            n_gnt++; g_wait = 0;
          end else g_wait++;
        end
      end
    end
  end

  task automatic clear_counts();
    n_valid = 0; n_last = 0; n_cap = 0; n_done = 0; n_req = 0;
    n_data_err = 0; n_unstable = 0; n_gnt = 0; res_k = 0;
  endtask

  task automatic setup(input int cap, input int lib, input int ls, input int bc,
                       input int gd, input int rd);
    cap_addr_i = WW'(cap); lib_addr_i = WW'(lib);
    lib_size_i = 9'(ls); band_cnt_i = 8'(bc);
    gnt_dly = gd; rv_dly = rd;
    clear_counts();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1;
    @(posedge clk); #1 start_i = 0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_i = 1;
    @(posedge clk); #1 clear_i = 0;
  endtask

  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles && n_done == 0; i++) begin
      @(posedge clk); #2;
    end
    asserts++;
    if (n_done == 0) begin
      failures++;
      $display("FAIL done_timeout: got no done_o, required done_o within %0d cycles", max_cycles);
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #2;
    asserts++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    asserts++; if (obi_req_o !== 1'b0 || obi_addr_o !== '0) begin failures++; $display("FAIL reset_obi: got req=%b addr=%h required 0/0", obi_req_o, obi_addr_o); end
    asserts++; if ({done_o, err_o, irq_o, dp_valid_o} !== 4'b0) begin failures++; $display("FAIL reset_flags: got %b required 0000", {done_o, err_o, irq_o, dp_valid_o}); end
    asserts++; if (best_idx_o !== 8'd0 || best_dist_o !== ONES) begin failures++; $display("FAIL reset_best: got idx=%0d dist=%h required 0/all-ones", best_idx_o, best_dist_o); end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_basic();
    setup(32'h1000, 32'h2000, 3, 4, 0, 0);
    res_q[0] = 30; res_q[1] = 10; res_q[2] = 20;
    pulse_start();
    wait_done(1000);
    asserts++; if (n_done !== 1) begin failures++; $display("FAIL basic_done_count: got %0d required 1", n_done); end
    asserts++; if (best_idx_o !== 8'd1 || best_dist_o !== AW'(10)) begin failures++; $display("FAIL basic_best: got idx=%0d dist=%0d required 1/10", best_idx_o, best_dist_o); end
    asserts++; if (n_valid !== 16 || n_last !== 4 || n_cap !== 4) begin failures++; $display("FAIL basic_beats: got valid=%0d last=%0d cap=%0d required 16/4/4", n_valid, n_last, n_cap); end
    asserts++; if (n_data_err !== 0) begin failures++; $display("FAIL basic_data: got %0d bad samples required 0", n_data_err); end
    asserts++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin failures++; $display("FAIL basic_status: got busy=%b err=%b required 0/0", busy_o, err_o); end
    repeat (5) @(posedge clk);
    #2;
    asserts++; if (irq_o !== 1'b1) begin failures++; $display("FAIL basic_irq_hold: got %b required 1", irq_o); end
    pulse_clear();
    #1;
    asserts++; if (irq_o !== 1'b0) begin failures++; $display("FAIL basic_irq_clear: got %b required 0", irq_o); end
  endtask

  task automatic test_ties();
    setup(32'h1000, 32'h2000, 3, 4, 0, 0);
    res_q[0] = 10; res_q[1] = 10; res_q[2] = 10;
    pulse_start();
    wait_done(1000);
    asserts++; if (best_idx_o !== 8'd0 || best_dist_o !== AW'(10)) begin failures++; $display("FAIL ties_best: got idx=%0d dist=%0d required 0/10", best_idx_o, best_dist_o); end
    pulse_clear();
  endtask

  task automatic test_lib_zero();
    setup(32'h1000, 32'h2000, 0, 4, 0, 0);
    @(posedge clk); #1 start_i = 1; clear_i = 1;
    @(posedge clk); #1 start_i = 0;
    asserts++; if (done_o !== 1'b0) begin failures++; $display("FAIL libzero_done_early: got %b required 0", done_o); end
    @(posedge clk); #1 clear_i = 0;
    asserts++; if (done_o !== 1'b1) begin failures++; $display("FAIL libzero_done_at2: got %b required 1", done_o); end
    asserts++; if (irq_o !== 1'b1) begin failures++; $display("FAIL libzero_irq_vs_clear: got %b required 1", irq_o); end
    repeat (3) @(posedge clk);
    #2;
    asserts++; if (n_req !== 0 || err_o !== 1'b0) begin failures++; $display("FAIL libzero_noobi: got req_cycles=%0d err=%b required 0/0", n_req, err_o); end
    asserts++; if (best_idx_o !== 8'd0 || best_dist_o !== ONES) begin failures++; $display("FAIL libzero_best: got idx=%0d dist=%h required 0/all-ones", best_idx_o, best_dist_o); end
    pulse_clear();
  endtask

  task automatic test_band_err();
    setup(32'h1000, 32'h2000, 3, 0, 0, 0);
    pulse_start();
    wait_done(20);
    asserts++; if (err_o !== 1'b1 || n_req !== 0) begin failures++; $display("FAIL band0_err: got err=%b req_cycles=%0d required 1/0", err_o, n_req); end
    setup(32'h1000, 32'h2000, 3, 129, 0, 0);
    pulse_start();
    wait_done(20);
    asserts++; if (err_o !== 1'b1 || n_req !== 0) begin failures++; $display("FAIL band129_err: got err=%b req_cycles=%0d required 1/0", err_o, n_req); end
    pulse_clear();
  endtask

  task automatic test_delays();
    int seq_err;
    setup(32'h1000, 32'h2000, 3, 4, 5, 3);
    res_q[0] = 5; res_q[1] = 6; res_q[2] = 7;
    pulse_start();
    #1;
    asserts++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL delays_start: got err=%b busy=%b required 0/1", err_o, busy_o); end
    wait_done(3000);
    asserts++; if (n_unstable !== 0) begin failures++; $display("FAIL delays_addr_stable: got %0d changes required 0", n_unstable); end
    asserts++; if (n_valid !== 16 || n_last !== 4) begin failures++; $display("FAIL delays_beats: got valid=%0d last=%0d required 16/4", n_valid, n_last); end
    seq_err = 0;
    for (int i = 0; i < 4; i++) if (gaddr[i] !== 32'h1000 + 32'(4 * i)) seq_err++;
    for (int i = 0; i < 12; i++) if (gaddr[4 + i] !== 32'h2000 + 32'(4 * i)) seq_err++;
    asserts++; if (n_gnt !== 16 || seq_err !== 0) begin failures++; $display("FAIL delays_addr_seq: got grants=%0d bad_addrs=%0d required 16/0", n_gnt, seq_err); end
    asserts++; if (best_idx_o !== 8'd0 || best_dist_o !== AW'(5)) begin failures++; $display("FAIL delays_best: got idx=%0d dist=%0d required 0/5", best_idx_o, best_dist_o); end
    pulse_clear();
  endtask

  task automatic test_busy_and_reset();
    bit hit;
    setup(32'h1000, 32'h2000, 2, 4, 0, 0);
    res_q[0] = 9; res_q[1] = 3;
    pulse_start();
    repeat (8) @(posedge clk);
    band_cnt_i = 8'd0; lib_size_i = 9'd0;
    pulse_start();
    wait_done(1000);
    repeat (5) @(posedge clk);
    #2;
    asserts++; if (n_done !== 1 || err_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL busy_start_ignored: got done=%0d err=%b busy=%b required 1/0/0", n_done, err_o, busy_o); end
    asserts++; if (best_idx_o !== 8'd1 || best_dist_o !== AW'(3)) begin failures++; $display("FAIL busy_best: got idx=%0d dist=%0d required 1/3", best_idx_o, best_dist_o); end
    pulse_clear();
    // reset while the first reference read is outstanding
    setup(32'h1000, 32'h2000, 2, 4, 0, 3);
    pulse_start();
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk); #2;
      if (n_gnt >= 5) hit = 1;
    end
    asserts++; if (!hit) begin failures++; $display("FAIL rst_reach_refwait: got %0d grants required 5", n_gnt); end
    @(posedge clk); #2 rst = 1;
    #1;
    asserts++; if (obi_req_o !== 1'b0 || busy_o !== 1'b0 || obi_addr_o !== '0) begin failures++; $display("FAIL rst_mid_obi: got req=%b busy=%b addr=%h required 0/0/0", obi_req_o, busy_o, obi_addr_o); end
    asserts++; if (best_idx_o !== 8'd0 || best_dist_o !== ONES || {done_o, err_o, irq_o, dp_valid_o} !== 4'b0) begin failures++; $display("FAIL rst_mid_status: got idx=%0d dist=%h flags=%b required 0/all-ones/0000", best_idx_o, best_dist_o, {done_o, err_o, irq_o, dp_valid_o}); end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    clear_counts();
    repeat (6) @(posedge clk);
    #2;
    asserts++; if (busy_o !== 1'b0 || n_req !== 0 || n_valid !== 0) begin failures++; $display("FAIL rst_idle: got busy=%b req_cycles=%0d beats=%0d required 0/0/0", busy_o, n_req, n_valid); end
    setup(32'h3000, 32'h4000, 1, 2, 0, 0);
    res_q[0] = 7;
    pulse_start();
    wait_done(500);
    asserts++; if (best_idx_o !== 8'd0 || best_dist_o !== AW'(7) || n_valid !== 4) begin failures++; $display("FAIL rst_rerun: got idx=%0d dist=%0d beats=%0d required 0/7/4", best_idx_o, best_dist_o, n_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_lib_zero();
    test_band_err();
    test_delays();
    test_busy_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
`default_nettype wire
